// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out front end: takes a WIDTH-bit word over valid/ready and
// shifts it out one bit per clock, streaming back-to-back words without a gap.
module piso_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             x_out_q, x_out_d;
    logic             x_valid_q, x_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;
    logic             xfer;

    assign din_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST));
    assign xfer      = din_valid && din_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        x_out_d       = IDLE_BIT;
        x_valid_d     = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = SHIFT;
                    shreg_d = din;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // Outputs are registered one edge behind the load, giving the 1-clk latency.
                x_out_d       = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
                x_valid_d     = 1'b1;
                busy_d        = 1'b1;
                frame_start_d = (cnt_q == '0);
                if (cnt_q == LAST) begin
                    if (xfer) begin
                        shreg_d = din;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                               : {1'b0, shreg_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            x_out_q       <= IDLE_BIT;
            x_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            x_out_q       <= x_out_d;
            x_valid_q     <= x_valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign x_out       = x_out_q;
    assign x_valid     = x_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: three configurations driven in parallel and
// compared each cycle against a bit-count reference model.
module tb_piso_bit_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Configurations: 0 = W8 MSB-first, 1 = W8 LSB-first idle 1, 2 = W2 MSB-first
    int unsigned W  [3] = '{8, 8, 2};
    bit          MF [3] = '{1'b1, 1'b0, 1'b1};
    bit          IB [3] = '{1'b0, 1'b1, 1'b0};

    logic        v   [3];
    logic [31:0] d   [3];
    logic        rdy [3];
    logic        xo  [3];
    logic        xv  [3];
    logic        fs  [3];
    logic        bz  [3];

    logic [7:0] din0, din1;
    logic [1:0] din2;
    assign din0 = d[0][7:0];
    assign din1 = d[1][7:0];
    assign din2 = d[2][1:0];

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(v[0]), .din_ready(rdy[0]),
        .x_out(xo[0]), .x_valid(xv[0]), .frame_start(fs[0]), .busy(bz[0]));
    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b1)) u1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(v[1]), .din_ready(rdy[1]),
        .x_out(xo[1]), .x_valid(xv[1]), .frame_start(fs[1]), .busy(bz[1]));
    piso_bit_serializer #(.WIDTH(2), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u2 (
        .clk(clk), .rst(rst), .din(din2), .din_valid(v[2]), .din_ready(rdy[2]),
        .x_out(xo[2]), .x_valid(xv[2]), .frame_start(fs[2]), .busy(bz[2]));

    // Reference model: bits of the current word still to be emitted, plus expected outputs
    int unsigned rem  [3];
    logic [31:0] word [3];
    logic        e_xo [3];
    logic        e_xv [3];
    logic        e_fs [3];
    logic        e_bz [3];

    // Directed word lists, consumed in order while the directed phase is active
    logic [31:0] dir [3][4];
    int unsigned dn  [3];
    int unsigned dp  [3];
    bit          directed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_ready(int unsigned i);
        return (rem[i] == 0) || (rem[i] == 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            rem[i]  = 0;
            word[i] = '0;
            e_xo[i] = IB[i];
            e_xv[i] = 1'b0;
            e_fs[i] = 1'b0;
            e_bz[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit r;
            int unsigned idx, pos;
            r = model_ready(i);
            if (rem[i] > 0) begin
                idx     = W[i] - rem[i];
                pos     = MF[i] ? (W[i] - 1 - idx) : idx;
                e_xo[i] = word[i][pos];
                e_xv[i] = 1'b1;
                e_fs[i] = (idx == 0);
                e_bz[i] = 1'b1;
                rem[i]  = rem[i] - 1;
            end else begin
                e_xo[i] = IB[i];
                e_xv[i] = 1'b0;
                e_fs[i] = 1'b0;
                e_bz[i] = 1'b0;
            end
            if (v[i] && r) begin
                word[i] = d[i] & ((32'd1 << W[i]) - 32'd1);
                rem[i]  = W[i];
                if (directed && dp[i] < dn[i]) dp[i]++;
            end
        end
    endtask

    task automatic check_outputs(input bit with_ready);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d x_out", i), 32'(xo[i]), 32'(e_xo[i]));
            check($sformatf("u%0d x_valid", i), 32'(xv[i]), 32'(e_xv[i]));
            check($sformatf("u%0d frame_start", i), 32'(fs[i]), 32'(e_fs[i]));
            check($sformatf("u%0d busy", i), 32'(bz[i]), 32'(e_bz[i]));
            if (with_ready)
                check($sformatf("u%0d din_ready", i), 32'(rdy[i]), 32'(model_ready(i)));
        end
    endtask

    // One clock: check at negedge, drive, then advance the model on posedge
    task automatic cycle(input int unsigned mode);
        @(negedge clk);
        check_outputs(1'b1);
        for (int i = 0; i < 3; i++) begin
            if (mode == 0) begin
                v[i] = (dp[i] < dn[i]);
                d[i] = v[i] ? dir[i][dp[i]] : $urandom;
            end else if (mode == 1) begin
                v[i] = ($urandom_range(0, 9) < 7);
                d[i] = $urandom;
            end else begin
                v[i] = 1'b0;
                d[i] = $urandom;
            end
        end
        @(posedge clk);
        model_edge();
    endtask

    task automatic load_directed(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        dir[0][0] = a0; dn[0] = 1; dp[0] = 0;
        dir[1][0] = a1; dn[1] = 1; dp[1] = 0;
        dir[2][0] = a2; dn[2] = 1; dp[2] = 0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0;
            d[i] = '0;
        end
        model_reset();
        #12;
        check_outputs(1'b0);
        @(negedge clk);
        rst = 1'b1;

        // D0, then DD/B0 streamed back-to-back; 0B LSB-first; W2 alternating 11/01
        directed  = 1'b1;
        dir[0] = '{32'hD0, 32'hDD, 32'hB0, 32'h0}; dn[0] = 3; dp[0] = 0;
        dir[1] = '{32'h0B, 32'h0, 32'h0, 32'h0};   dn[1] = 1; dp[1] = 0;
        dir[2] = '{32'h3, 32'h1, 32'h3, 32'h1};    dn[2] = 4; dp[2] = 0;
        for (int c = 0; c < 30; c++) cycle(0);

        // Mid-word reset: load FF, let four bits out, then assert rst asynchronously
        load_directed(32'hFF, 32'hFF, 32'h3);
        cycle(0);
        for (int c = 0; c < 4; c++) cycle(2);
        @(negedge clk);
        check_outputs(1'b1);
        #1 rst = 1'b0;
        model_reset();
        #1 check_outputs(1'b0);
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b1;
            d[i] = 32'hFF;
        end
        @(posedge clk);
        #1 check_outputs(1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) v[i] = 1'b0;
        @(posedge clk);
        model_edge();

        load_directed(32'hA5, 32'hA5, 32'h2);
        for (int c = 0; c < 14; c++) cycle(0);

        directed = 1'b0;
        for (int c = 0; c < 400; c++) cycle(1);
        for (int c = 0; c < 12; c++) cycle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
